// File: rtl/demux_1_2_32_buf.sv
// 1-to-2 demultiplexer for 32-bit words with a 2-entry FIFO on each output
// channel and a running count of accepted input words.
module demux_1_2_32_buf #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_sel,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out0_data,
    output logic        out0_valid,
    input  logic        out0_ready,
    output logic [31:0] out1_data,
    output logic        out1_valid,
    input  logic        out1_ready,
    output logic [1:0]  cnt0,
    output logic [1:0]  cnt1,
    output logic [15:0] xfer_count
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [31:0] mem0 [2];
    logic [31:0] mem1 [2];
    logic        wp0, rp0, wp1, rp1;
    logic        accept, push0, push1, pop0, pop1;

    // in_ready looks only at registered counts, never at the consumer side.
    assign in_ready = in_sel ? (cnt1 < FULL) : (cnt0 < FULL);

    assign accept = in_valid && in_ready && !rst;
    assign push0  = accept && !in_sel;
    assign push1  = accept && in_sel;
    assign pop0   = out0_valid && out0_ready;
    assign pop1   = out1_valid && out1_ready;

    assign out0_valid = (cnt0 != 2'd0);
    assign out1_valid = (cnt1 != 2'd0);
    assign out0_data  = mem0[rp0];
    assign out1_data  = mem1[rp1];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0       <= '0;
            cnt1       <= '0;
            wp0        <= 1'b0;
            rp0        <= 1'b0;
            wp1        <= 1'b0;
            rp1        <= 1'b0;
            xfer_count <= '0;
        end else begin
            if (push0) wp0 <= ~wp0;
            if (pop0)  rp0 <= ~rp0;
            if (push1) wp1 <= ~wp1;
            if (pop1)  rp1 <= ~rp1;

            case ({push0, pop0})
                2'b10:   cnt0 <= cnt0 + 2'd1;
                2'b01:   cnt0 <= cnt0 - 2'd1;
                default: cnt0 <= cnt0;
            endcase

            case ({push1, pop1})
                2'b10:   cnt1 <= cnt1 + 2'd1;
                2'b01:   cnt1 <= cnt1 - 2'd1;
                default: cnt1 <= cnt1;
            endcase

            if (accept) xfer_count <= xfer_count + 16'd1;
        end
    end

    // Storage carries no reset; validity is tracked by the counts alone.
    always_ff @(posedge clk) begin
        if (push0) mem0[wp0] <= in_data;
        if (push1) mem1[wp1] <= in_data;
    end

endmodule
